// File: rtl/arm7tdmi_operand2_stage_if.sv
// arm7tdmi_operand2_stage_if: decode-side, register-file and ALU-side signals of the operand-2 stage
interface arm7tdmi_operand2_stage_if;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic        imm_en;
   logic [11:0] immediate;
   logic [1:0]  shift_type;
   logic [4:0]  shift_amount;
   logic        shift_reg;
   logic [3:0]  shift_rs;
   logic [31:0] rm_data;
   logic        carry_in;
   logic        rs_rd_en;
   logic [3:0]  rs_addr;
   logic [31:0] rs_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] op2_data;
   logic        op2_carry;
   modport master (
      output flush, in_valid, imm_en, immediate, shift_type, shift_amount, shift_reg, shift_rs,
             rm_data, carry_in, rs_data, out_ready,
      input  in_ready, rs_rd_en, rs_addr, out_valid, op2_data, op2_carry
   );
   modport slave (
      input  flush, in_valid, imm_en, immediate, shift_type, shift_amount, shift_reg, shift_rs,
             rm_data, carry_in, rs_data, out_ready,
      output in_ready, rs_rd_en, rs_addr, out_valid, op2_data, op2_carry
   );
endinterface

// File: rtl/arm7tdmi_operand2_stage.sv
// arm7tdmi_operand2_stage: barrel shifter / rotated-immediate expander producing ALU operand 2 and carry-out
module arm7tdmi_operand2_stage #(
   parameter int RS_READ_LATENCY = 1
) (
   input logic clk,
   input logic rst,
   arm7tdmi_operand2_stage_if.slave bus
);
   localparam logic [1:0] LSL = 2'd0;
   localparam logic [1:0] LSR = 2'd1;
   localparam logic [1:0] ASR = 2'd2;
   typedef enum logic {IDLE, RS_WAIT} state_t;
   state_t      state, state_n;
   logic [1:0]  cnt, cnt_n;
   logic        out_valid, out_valid_n;
   logic [31:0] op2_data, op2_data_n;
   logic        op2_carry, op2_carry_n;
   logic [1:0]  type_q, type_n;
   logic [31:0] rm_q, rm_n;
   logic        ci_q, ci_n;
   logic        accept;
   logic        reg_op;
   logic [32:0] imm_res;
   logic [32:0] reg_res;
   logic        unused_rs;
   // Immediate-encoded shift; returns {carry, result}; amount 0 encodes LSL#0, LSR#32, ASR#32, RRX
   function automatic logic [32:0] sh_imm(input logic [31:0] d, input logic [1:0] t, input logic [4:0] a,
                                          input logic ci);
      logic [32:0] l, r, as;
      logic [31:0] ro;
      l  = {1'b0, d} << a;
      r  = {d, 1'b0} >> a;
      as = 33'($signed({d, 1'b0}) >>> a);
      ro = (d >> a) | (d << (6'd32 - {1'b0, a}));
      return (a == 5'd0) ?
         ((t == LSL) ? {ci, d} : (t == LSR) ? {d[31], 32'd0} : (t == ASR) ? {33{d[31]}} : {d[0], ci, d[31:1]}) :
         ((t == LSL) ? l : (t == LSR) ? {r[0], r[32:1]} : (t == ASR) ? {as[0], as[32:1]} : {ro[31], ro});
   endfunction
   // Register-specified shift by the full low byte of Rs, including the >=32 cases
   function automatic logic [32:0] sh_reg(input logic [31:0] d, input logic [1:0] t, input logic [7:0] n,
                                          input logic ci);
      logic big;
      big = n[7:5] != 3'd0;
      return (n == 8'd0) ? {ci, d} :
             (t == 2'd3) ? ((n[4:0] == 5'd0) ? {d[31], d} : sh_imm(d, t, n[4:0], ci)) :
             !big ? sh_imm(d, t, n[4:0], ci) :
             (t == ASR) ? {33{d[31]}} :
             (n != 8'd32) ? 33'd0 :
             (t == LSL) ? {d[0], 32'd0} : {d[31], 32'd0};
   endfunction
   // 8-bit immediate rotated right by twice the 4-bit rotate field
   function automatic logic [32:0] rot_imm(input logic [11:0] im, input logic ci);
      logic [4:0]  rot;
      logic [31:0] r;
      rot = {im[11:8], 1'b0};
      r   = ({24'd0, im[7:0]} >> rot) | ({24'd0, im[7:0]} << (6'd32 - {1'b0, rot}));
      return {(rot == 5'd0) ? ci : r[31], r};
   endfunction
   assign bus.in_ready  = (state == IDLE) && (!out_valid || bus.out_ready) && !bus.flush;
   assign accept        = bus.in_valid && bus.in_ready;
   assign reg_op        = bus.shift_reg && !bus.imm_en;
   assign bus.rs_rd_en  = accept && reg_op;
   assign bus.rs_addr   = bus.rs_rd_en ? bus.shift_rs : 4'd0;
   assign bus.out_valid = out_valid;
   assign bus.op2_data  = op2_data;
   assign bus.op2_carry = op2_carry;
   assign imm_res       = bus.imm_en ? rot_imm(bus.immediate, bus.carry_in)
                                     : sh_imm(bus.rm_data, bus.shift_type, bus.shift_amount, bus.carry_in);
   assign reg_res       = sh_reg(rm_q, type_q, bus.rs_data[7:0], ci_q);
   assign unused_rs     = ^bus.rs_data[31:8];
   // Next-state: accept, Rs wait countdown, result capture, drain and flush
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      out_valid_n = out_valid && !bus.out_ready;
      op2_data_n  = op2_data;
      op2_carry_n = op2_carry;
      type_n      = type_q;
      rm_n        = rm_q;
      ci_n        = ci_q;
      if (bus.flush) begin
         state_n     = IDLE;
         cnt_n       = 2'd0;
         out_valid_n = 1'b0;
      end else if (accept && reg_op) begin
         state_n = RS_WAIT;
         cnt_n   = 2'(RS_READ_LATENCY - 1);
         type_n  = bus.shift_type;
         rm_n    = bus.rm_data;
         ci_n    = bus.carry_in;
      end else if (accept) begin
         out_valid_n              = 1'b1;
         {op2_carry_n, op2_data_n} = imm_res;
      end else if (state == RS_WAIT && cnt == 2'd0) begin
         state_n                  = IDLE;
         out_valid_n              = 1'b1;
         {op2_carry_n, op2_data_n} = reg_res;
      end else if (state == RS_WAIT) begin
         cnt_n = cnt - 2'd1;
      end
   end
   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 2'd0;
         out_valid <= 1'b0;
         op2_data  <= 32'd0;
         op2_carry <= 1'b0;
         type_q    <= 2'd0;
         rm_q      <= 32'd0;
         ci_q      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         out_valid <= out_valid_n;
         op2_data  <= op2_data_n;
         op2_carry <= op2_carry_n;
         type_q    <= type_n;
         rm_q      <= rm_n;
         ci_q      <= ci_n;
      end
   end
endmodule
